// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: mode encoding, ShiftRows offsets and byte addressing.
package aes_pkg;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Left-rotate amount for row r. Wide blocks (NB = 8) use the larger offsets 0,1,3,4.
    function automatic int row_shift(input int nb, input int r);
        if (nb == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    // Row-major byte index inside the state.
    function automatic int byte_idx(input int nb, input int r, input int c);
        return r * nb + c;
    endfunction

    // Lowest bit position of byte k. Byte 0 occupies the most significant byte of
    // the vector, so a hex literal reads left-to-right as bytes 0,1,2,...
    function automatic int byte_lsb(input int nb, input int k);
        return 32 * nb - 8 * (k + 1);
    endfunction

endpackage

// File: rtl/shift_rows_core.sv
// Combinational forward/inverse ShiftRows for NB = 4, 6 or 8 columns.
module shift_rows_core
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] state,
    input  logic             mode,
    output logic [32*NB-1:0] new_state
);

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_core: NB must be 4, 6 or 8");
        end
    endgenerate

    // Pure wiring: every output byte selects one of two fixed source bytes by mode.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int SH      = row_shift(NB, r);
            localparam int DST     = byte_idx(NB, r, c);
            localparam int FWD_SRC = byte_idx(NB, r, (c + SH) % NB);
            localparam int INV_SRC = byte_idx(NB, r, (c - SH + NB) % NB);

            assign new_state[byte_lsb(NB, DST) +: 8] =
                (mode == MODE_INV) ? state[byte_lsb(NB, INV_SRC) +: 8]
                                   : state[byte_lsb(NB, FWD_SRC) +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming ShiftRows stage: combinational transform feeding a 2-entry output FIFO.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// The producer must hold its payload while valid && !ready. in_ready depends only on
// the registered occupancy, never combinationally on out_ready; out_state/out_tag
// are the head entry and do not change while out_valid && !out_ready.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [32*NB-1:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_stream: NB must be 4, 6 or 8");
        end
    endgenerate

    logic [32*NB-1:0] shifted;
    logic [32*NB-1:0] mem_state [2];
    logic [TAG_W-1:0] mem_tag   [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    shift_rows_core #(.NB(NB)) u_core (
        .state     (in_state),
        .mode      (in_mode),
        .new_state (shifted)
    );

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign busy      = out_valid;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy and pointers; only handshake bits feed these, never payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage holds the already-transformed state; it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_state[wr_ptr] <= shifted;
            mem_tag[wr_ptr]   <= in_tag;
        end
    end

    // Head entry when occupied, zero otherwise so reset shows a clean output.
    always_comb begin
        out_state = '0;
        out_tag   = '0;
        if (out_valid) begin
            out_state = mem_state[rd_ptr];
            out_tag   = mem_tag[rd_ptr];
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream (NB = 4 main instance, NB = 8 side instance).
module tb_shift_rows_stream;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;

    logic         in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, busy4;
    logic [3:0]   in_tag4, out_tag4;
    logic [127:0] in_state4, out_state4;

    logic         in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, busy8;
    logic [3:0]   in_tag8, out_tag8;
    logic [255:0] in_state8, out_state8;

    int total = 0;
    int bad = 0;

    logic [3:0]   exp_q[$];
    logic [127:0] exp_s_q[$];

    shift_rows_stream #(.NB(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_mode(in_mode4),
        .in_tag(in_tag4), .in_state(in_state4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_state(out_state4), .out_tag(out_tag4), .busy(busy4)
    );

    shift_rows_stream #(.NB(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_mode(in_mode8),
        .in_tag(in_tag8), .in_state(in_state8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_state(out_state8), .out_tag(out_tag8), .busy(busy8)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference for NB = 4: rotate each row of a 4x4 byte matrix left (fwd) or right (inv).
    function automatic logic [127:0] ref4(input logic [127:0] s, input logic m);
        logic [7:0]   b [4][4];
        logic [127:0] o;
        int           amt;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = s[127 - 8*(r*4 + c) -: 8];
        o = '0;
        for (int r = 0; r < 4; r++) begin
            amt = m ? (4 - r) % 4 : r;
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r*4 + c) -: 8] = b[r][(c + amt) % 4];
        end
        return o;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid4); end
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy4); end
        total++; if (out_state4 !== 128'h0) begin bad++; $display("FAIL reset_out_state got=%h want=0", out_state4); end
        total++; if (out_tag4 !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag4); end
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid8 got=%b want=0", out_valid8); end
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_inv4;
        out_ready4 = 1'b1;
        in_valid4  = 1'b1;
        in_mode4   = MODE_INV;
        in_tag4    = 4'h5;
        in_state4  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        tick;
        in_valid4 = 1'b0;
        total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL inv4_valid got=%b want=1", out_valid4); end
        total++; if (out_state4 !== 128'h00010203_07040506_0A0B0809_0D0E0F0C) begin bad++; $display("FAIL inv4_state got=%h want=%h", out_state4, 128'h00010203_07040506_0A0B0809_0D0E0F0C); end
        total++; if (out_tag4 !== 4'h5) begin bad++; $display("FAIL inv4_tag got=%h want=5", out_tag4); end
        tick;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL inv4_drained got=%b want=0", out_valid4); end
    endtask

    task automatic test_fwd4_roundtrip;
        logic [127:0] res;
        out_ready4 = 1'b1;
        in_valid4  = 1'b1;
        in_mode4   = MODE_FWD;
        in_tag4    = 4'h6;
        in_state4  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        tick;
        res = out_state4;
        total++; if (out_state4 !== 128'h00010203_05060704_0A0B0809_0F0C0D0E) begin bad++; $display("FAIL fwd4_state got=%h want=%h", out_state4, 128'h00010203_05060704_0A0B0809_0F0C0D0E); end
        total++; if (out_tag4 !== 4'h6) begin bad++; $display("FAIL fwd4_tag got=%h want=6", out_tag4); end
        // Back-to-back: feed the result back in inverse mode while the first pops.
        in_mode4  = MODE_INV;
        in_tag4   = 4'h7;
        in_state4 = res;
        tick;
        in_valid4 = 1'b0;
        total++; if (out_state4 !== 128'h00010203_04050607_08090A0B_0C0D0E0F) begin bad++; $display("FAIL roundtrip_state got=%h want=%h", out_state4, 128'h00010203_04050607_08090A0B_0C0D0E0F); end
        total++; if (out_tag4 !== 4'h7) begin bad++; $display("FAIL roundtrip_tag got=%h want=7", out_tag4); end
        tick;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL roundtrip_drained got=%b want=0", out_valid4); end
    endtask

    task automatic test_nb8;
        logic [255:0] s8;
        for (int k = 0; k < 32; k++) s8[255 - 8*k -: 8] = 8'(k);
        out_ready8 = 1'b1;
        in_valid8  = 1'b1;
        in_mode8   = MODE_FWD;
        in_tag8    = 4'h8;
        in_state8  = s8;
        tick;
        in_mode8 = MODE_INV;
        in_tag8  = 4'h9;
        total++; if (out_state8[255:192] !== 64'h0001020304050607) begin bad++; $display("FAIL nb8_fwd_row0 got=%h want=0001020304050607", out_state8[255:192]); end
        total++; if (out_state8[191:128] !== 64'h090A0B0C0D0E0F08) begin bad++; $display("FAIL nb8_fwd_row1 got=%h want=090A0B0C0D0E0F08", out_state8[191:128]); end
        total++; if (out_state8[127:64] !== 64'h1314151617101112) begin bad++; $display("FAIL nb8_fwd_row2 got=%h want=1314151617101112", out_state8[127:64]); end
        total++; if (out_state8[63:0] !== 64'h1C1D1E1F18191A1B) begin bad++; $display("FAIL nb8_fwd_row3 got=%h want=1C1D1E1F18191A1B", out_state8[63:0]); end
        total++; if (out_tag8 !== 4'h8) begin bad++; $display("FAIL nb8_fwd_tag got=%h want=8", out_tag8); end
        tick;
        in_valid8 = 1'b0;
        total++; if (out_state8[127:64] !== 64'h1516171011121314) begin bad++; $display("FAIL nb8_inv_row2 got=%h want=1516171011121314", out_state8[127:64]); end
        total++; if (out_state8[191:128] !== 64'h0F08090A0B0C0D0E) begin bad++; $display("FAIL nb8_inv_row1 got=%h want=0F08090A0B0C0D0E", out_state8[191:128]); end
        total++; if (out_tag8 !== 4'h9) begin bad++; $display("FAIL nb8_inv_tag got=%h want=9", out_tag8); end
        tick;
    endtask

    task automatic test_backpressure;
        logic [127:0] held;
        logic         acc, pp;
        logic [3:0]   et;
        logic [127:0] es;
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_mode4   = MODE_FWD;
        for (int t = 1; t <= 3; t++) begin
            exp_q.push_back(4'(t));
            exp_s_q.push_back(ref4(128'h00112233_44556677_8899AABB_CCDDEEFF ^ {16{8'(t)}}, MODE_FWD));
        end
        in_tag4   = 4'h1;
        in_state4 = 128'h00112233_44556677_8899AABB_CCDDEEFF ^ {16{8'h01}};
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b want=1", in_ready4); end
        tick;
        in_tag4   = 4'h2;
        in_state4 = 128'h00112233_44556677_8899AABB_CCDDEEFF ^ {16{8'h02}};
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b want=1", in_ready4); end
        tick;
        in_tag4   = 4'h3;
        in_state4 = 128'h00112233_44556677_8899AABB_CCDDEEFF ^ {16{8'h03}};
        total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", in_ready4); end
        held = out_state4;
        tick;
        tick;
        total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL bp_ready_hold got=%b want=0", in_ready4); end
        total++; if (out_tag4 !== 4'h1) begin bad++; $display("FAIL bp_head_tag got=%h want=1", out_tag4); end
        total++; if (out_state4 !== held) begin bad++; $display("FAIL bp_stable got=%h want=%h", out_state4, held); end
        total++; if (held !== exp_s_q[0]) begin bad++; $display("FAIL bp_head_state got=%h want=%h", held, exp_s_q[0]); end
        out_ready4 = 1'b1;
        for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) begin
            acc = in_valid4 && in_ready4;
            pp  = out_valid4 && out_ready4;
            if (pp) begin
                et = exp_q.pop_front();
                es = exp_s_q.pop_front();
                total++; if (out_tag4 !== et) begin bad++; $display("FAIL bp_order_tag got=%h want=%h", out_tag4, et); end
                total++; if (out_state4 !== es) begin bad++; $display("FAIL bp_order_state got=%h want=%h", out_state4, es); end
            end
            tick;
            if (acc) in_valid4 = 1'b0;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_timeout left=%0d want=0", exp_q.size()); end
        exp_q.delete();
        exp_s_q.delete();
        in_valid4 = 1'b0;
        tick;
    endtask

    task automatic test_concurrent;
        logic         acc, pp;
        logic [3:0]   et;
        logic [127:0] es;
        logic [3:0]   next_tag;
        next_tag   = 4'h0;
        in_valid4  = 1'b1;
        in_mode4   = MODE_FWD;
        in_tag4    = next_tag;
        in_state4  = {$urandom(), $urandom(), $urandom(), $urandom()};
        out_ready4 = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc == 70) in_valid4 = 1'b0;
            if (cyc >= 70) out_ready4 = 1'b1;
            total++; if (out_valid4 !== (exp_q.size() != 0)) begin bad++; $display("FAIL conc_valid cyc=%0d got=%b want=%b", cyc, out_valid4, exp_q.size() != 0); end
            total++; if (in_ready4 !== (exp_q.size() < 2)) begin bad++; $display("FAIL conc_ready cyc=%0d got=%b want=%b", cyc, in_ready4, exp_q.size() < 2); end
            acc = in_valid4 && in_ready4;
            pp  = out_valid4 && out_ready4;
            if (pp && exp_q.size() != 0) begin
                et = exp_q.pop_front();
                es = exp_s_q.pop_front();
                total++; if (out_tag4 !== et) begin bad++; $display("FAIL conc_tag cyc=%0d got=%h want=%h", cyc, out_tag4, et); end
                total++; if (out_state4 !== es) begin bad++; $display("FAIL conc_state cyc=%0d got=%h want=%h", cyc, out_state4, es); end
            end
            if (acc) begin
                exp_q.push_back(in_tag4);
                exp_s_q.push_back(ref4(in_state4, in_mode4));
            end
            tick;
            if (acc) begin
                next_tag  = next_tag + 4'h1;
                in_tag4   = next_tag;
                in_mode4  = ~in_mode4;
                in_state4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (cyc < 69) out_ready4 = 1'($urandom_range(0, 1));
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL conc_leftover got=%0d want=0", exp_q.size()); end
        exp_q.delete();
        exp_s_q.delete();
    endtask

    task automatic test_reset_midstream;
        logic [127:0] es;
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_mode4   = MODE_FWD;
        in_tag4    = 4'h8;
        in_state4  = 128'hDEADBEEF_00000000_11111111_22222222;
        tick;
        in_tag4 = 4'h9;
        tick;
        in_valid4 = 1'b0;
        total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL mid_full got=%b want=0", in_ready4); end
        #2 rst_n = 1'b0;
        tick;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid4); end
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy4); end
        rst_n = 1'b1;
        tick;
        out_ready4 = 1'b1;
        in_valid4  = 1'b1;
        in_mode4   = MODE_INV;
        in_tag4    = 4'hA;
        in_state4  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        es = 128'h0F0E0D0C_080B0A09_05040706_02010003;
        tick;
        in_valid4 = 1'b0;
        total++; if (out_tag4 !== 4'hA) begin bad++; $display("FAIL mid_new_tag got=%h want=a", out_tag4); end
        total++; if (out_state4 !== es) begin bad++; $display("FAIL mid_new_state got=%h want=%h", out_state4, es); end
        tick;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL mid_only_new got=%b want=0", out_valid4); end
    endtask

    initial begin
        in_valid4 = 1'b0; in_mode4 = 1'b0; in_tag4 = '0; in_state4 = '0; out_ready4 = 1'b0;
        in_valid8 = 1'b0; in_mode8 = 1'b0; in_tag8 = '0; in_state8 = '0; out_ready8 = 1'b0;
        test_reset;
        test_inv4;
        test_fwd4_roundtrip;
        test_nb8;
        test_backpressure;
        test_concurrent;
        test_reset_midstream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
- Parametrised, pipelined ShiftRows engine covering forward and inverse transforms for Rijndael block widths Nb = 4, 6, 8 columns.
- Replaces the fixed 128-bit inverse-only combinational mapping in both the encrypt and decrypt round datapaths.
- Adds a per-transaction mode bit, a sideband tag, valid/ready handshakes and a 2-entry output buffer, so round stages can stall independently.

Parameters:
- NB, 4, number of state columns. Legal values are 4, 6, 8; any other value is an elaboration error.
- TAG_W, 4, width of the sideband tag carried alongside each state.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input state, mode and tag are valid.
- in_ready  out  1  block can accept a transaction this cycle.
- in_mode  in  1  0 = forward ShiftRows, 1 = inverse ShiftRows.
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- in_state  in  32*NB  state, bit order [0:32*NB-1], byte k = bits [8k:8k+7].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_state  out  32*NB  transformed state.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  buffer non-empty.

Behaviour:
- Byte layout is row-major: byte index = r*NB + c, with r in 0..3 and c in 0..NB-1.
- Row shift s(r):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse: out[r][c] = in[r][(c - s(r) + NB) mod NB].
- The transform is combinational on the input side. The result and tag are written into a 2-entry FIFO (entries 0/1, 1-bit write/read pointers, 2-bit count).
- Handshakes:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != 2). It is registered-state derived and has no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_state and out_tag come from the head entry and stay stable while out_valid && !out_ready.
- Latency: a transaction accepted at edge N is presented with out_valid = 1 after edge N (1 cycle) when the buffer was empty. Sustained throughput is 1 per cycle with out_ready held high.
- Push and pop in the same cycle with count = 1: count stays 1, both pointers advance, and the new entry becomes head in the next cycle.
- Count = 2: in_ready = 0. An in_valid asserted in this cycle is ignored, and the upstream side must hold its data.
- Count = 0 with out_ready = 1: no pop and no pointer change.
- Pointers wrap modulo 2.
- Each entry stores the mode-resolved result. Changing mode between consecutive transactions takes effect immediately with no bubble.
- Reset (any time, including mid-stream): count = 0, pointers = 0, out_valid = 0, in_ready = 1, busy = 0.
  - out_state and out_tag reset to 0; buffer entry storage is not reset.
  - Buffered data is discarded, and the first post-reset acceptance behaves as from empty.
- in_* values are don't-care when in_valid = 0. X on in_state is not allowed to corrupt count or pointers.

Decomposition:
- Shared package aes_pkg holds:
  - MODE_FWD = 1'b0 and MODE_INV = 1'b1.
  - Function row_shift(nb, r) returning s(r).
  - Function byte_idx(nb, r, c).
- Sub-module shift_rows_core (NB), purely combinational: inputs state and mode, output new_state, implemented with generate loops over r and c. It is reusable by the unrolled round pipeline.
- shift_rows_stream contains the FIFO, pointers and handshake logic only.

Test Plan:
- NB = 4, inverse, bytes 00..0F, out_ready = 1:
  - Result 1 cycle later is 00 01 02 03 07 04 05 06 0A 0B 08 09 0D 0E 0F 0C.
  - Tag 0x5 is echoed.
- NB = 4, forward, bytes 00..0F:
  - Result is 00 01 02 03 05 06 07 04 0A 0B 08 09 0F 0C 0D 0E.
  - Feed this back with inverse mode and check that 00..0F is recovered (round-trip).
- NB = 8, forward, bytes 00..1F:
  - Row 2 (bytes 10..17) becomes 13 14 15 16 17 10 11 12.
  - Row 3 (bytes 18..1F) becomes 1C 1D 1E 1F 18 19 1A 1B.
- Backpressure: out_ready = 0 while pushing 3 transactions with tags 1, 2, 3:
  - in_ready drops after 2 accepts, and tag 3 is held.
  - Release out_ready: outputs appear in order 1, 2, 3, and out_state is stable during the stall.
- Concurrent traffic: alternating modes, in_valid = 1 continuously, random out_ready:
  - Scoreboard against the reference model with no loss or duplication.
  - Count never exceeds 2.
- Reset mid-stream with 2 entries buffered:
  - Next cycle shows out_valid = 0, in_ready = 1, busy = 0.
  - A new push produces only the new result.
